// File: rtl/xm23_alu_if.sv
// rtl/xm23_alu_if.sv - operand/result bundle between the XM23 control unit and ALU
interface xm23_alu_if;
  logic [15:0] d_bus;
  logic [15:0] s_bus;
  logic [5:0]  alu_op;
  logic [15:0] psw_in;
  logic        psw_update;
  logic [15:0] alu_out;
  logic [15:0] alu_psw_out;

  modport master (
    output d_bus, s_bus, alu_op, psw_in, psw_update,
    input  alu_out, alu_psw_out
  );

  modport slave (
    input  d_bus, s_bus, alu_op, psw_in, psw_update,
    output alu_out, alu_psw_out
  );
endinterface

// File: rtl/xm23_alu.sv
// rtl/xm23_alu.sv - registered 16-bit XM23 ALU; BCD add built only with XM23_ALU_DADD_EN
// Byte mode works on bits 7:0 and carries d_bus[15:8] through untouched.
module xm23_alu (
  input  logic      Clock,
  input  logic      Reset,
  xm23_alu_if.slave bus
);
  localparam logic [4:0] OP_ADD  = 5'd0,  OP_ADDC = 5'd1,  OP_SUB  = 5'd2,  OP_SUBC = 5'd3;
  localparam logic [4:0] OP_DADD = 5'd4,  OP_CMP  = 5'd5,  OP_XOR  = 5'd6,  OP_AND  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8,  OP_BIT  = 5'd9,  OP_BIC  = 5'd10, OP_BIS  = 5'd11;
  localparam logic [4:0] OP_MOV  = 5'd12, OP_SRA  = 5'd13, OP_RRC  = 5'd14, OP_SWPB = 5'd15;
  localparam logic [4:0] OP_SXT  = 5'd16;

  logic [15:0] alu_out_q, alu_out_d;
  logic [15:0] psw_q, psw_d;

  logic [4:0]  op;
  logic [15:0] d, s, b_op, val, fres;
  logic        eb, c_in, cin;
  logic [16:0] sum_w;
  logic [8:0]  sum_b;
  logic [15:0] add_val;
  logic        add_c, add_v, dm, bm, rm;
  logic        keep_d, upd_zn, upd_c, upd_v, c_new, v_new, z_new, n_new;

`ifdef XM23_ALU_DADD_EN
  logic [15:0] dadd_val;
  logic        dadd_c;
  logic [4:0]  dsum;
  logic        dc, dc_b;

  // Per-digit decimal add; raw digit sums above 9 get +6 and carry onward.
  always_comb begin
    dadd_val = 16'h0000;
    dc       = bus.psw_in[0];
    dc_b     = 1'b0;
    dsum     = 5'd0;
    for (int i = 0; i < 4; i++) begin
      dsum = {1'b0, bus.d_bus[4*i +: 4]} + {1'b0, bus.s_bus[4*i +: 4]} + {4'b0, dc};
      dc   = (dsum > 5'd9);
      if (dc) dsum = dsum + 5'd6;
      dadd_val[4*i +: 4] = dsum[3:0];
      if (i == 1) dc_b = dc;
    end
    dadd_c = eb ? dc_b : dc;
  end
`endif

  always_comb begin
    op   = bus.alu_op[4:0];
    d    = bus.d_bus;
    s    = bus.s_bus;
    c_in = bus.psw_in[0];
    eb   = bus.alu_op[5] && (op != OP_SWPB) && (op != OP_SXT);

    b_op = (op == OP_SUB || op == OP_SUBC || op == OP_CMP) ? ~s : s;
    case (op)
      OP_ADD:           cin = 1'b0;
      OP_SUB, OP_CMP:   cin = 1'b1;
      default:          cin = c_in;
    endcase
    sum_w   = {1'b0, d} + {1'b0, b_op} + {16'b0, cin};
    sum_b   = {1'b0, d[7:0]} + {1'b0, b_op[7:0]} + {8'b0, cin};
    add_val = eb ? {8'h00, sum_b[7:0]} : sum_w[15:0];
    add_c   = eb ? sum_b[8] : sum_w[16];
    dm      = eb ? d[7] : d[15];
    bm      = eb ? b_op[7] : b_op[15];
    rm      = eb ? sum_b[7] : sum_w[15];
    add_v   = (dm == bm) && (rm != dm);

    val    = d;
    keep_d = 1'b0;
    upd_zn = 1'b0;
    upd_c  = 1'b0;
    upd_v  = 1'b0;
    c_new  = c_in;
    v_new  = bus.psw_in[4];

    case (op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: begin
        val    = add_val;
        keep_d = (op == OP_CMP);
        c_new  = add_c;
        v_new  = add_v;
        upd_zn = 1'b1;
        upd_c  = 1'b1;
        upd_v  = 1'b1;
      end
`ifdef XM23_ALU_DADD_EN
      OP_DADD: begin
        val    = dadd_val;
        c_new  = dadd_c;
        upd_zn = 1'b1;
        upd_c  = 1'b1;
      end
`endif
      OP_XOR, OP_AND, OP_OR, OP_BIT, OP_BIC, OP_BIS: begin
        case (op)
          OP_XOR:        val = d ^ s;
          OP_OR, OP_BIS: val = d | s;
          OP_BIC:        val = d & ~s;
          default:       val = d & s;
        endcase
        keep_d = (op == OP_BIT);
        v_new  = 1'b0;
        upd_zn = 1'b1;
        upd_v  = 1'b1;
      end
      OP_MOV: val = s;
      OP_SRA, OP_RRC: begin
        if (op == OP_SRA)
          val = eb ? {8'h00, d[7], d[7:1]} : {d[15], d[15:1]};
        else
          val = eb ? {8'h00, c_in, d[7:1]} : {c_in, d[15:1]};
        c_new  = d[0];
        upd_zn = 1'b1;
        upd_c  = 1'b1;
      end
      OP_SWPB: begin
        val    = {d[7:0], d[15:8]};
        upd_zn = 1'b1;
      end
      OP_SXT: begin
        val    = {{8{d[7]}}, d[7:0]};
        upd_zn = 1'b1;
      end
      default: val = d;
    endcase

    fres      = eb ? {d[15:8], val[7:0]} : val;
    z_new     = eb ? (fres[7:0] == 8'h00) : (fres == 16'h0000);
    n_new     = eb ? fres[7] : fres[15];
    alu_out_d = keep_d ? d : fres;

    psw_d = bus.psw_in;
    if (bus.psw_update) begin
      if (upd_c) psw_d[0] = c_new;
      if (upd_zn) begin
        psw_d[1] = z_new;
        psw_d[2] = n_new;
      end
      if (upd_v) psw_d[4] = v_new;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      alu_out_q <= 16'h0000;
      psw_q     <= 16'h0000;
    end else begin
      alu_out_q <= alu_out_d;
      psw_q     <= psw_d;
    end
  end

  assign bus.alu_out     = alu_out_q;
  assign bus.alu_psw_out = psw_q;
endmodule

// File: tb/tb_xm23_alu.sv
// tb/tb_xm23_alu.sv - vector table, reset sequences and random model comparison for xm23_alu
module tb_xm23_alu;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  xm23_alu_if bus();
  xm23_alu dut (.Clock(clk), .Reset(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [15:0] s;
    logic [5:0]  op;
    logic [15:0] pin;
    logic        upd;
    logic [15:0] eo;
    logic [15:0] ep;
  } vec_t;

  vec_t tbl[$];

  function automatic void add_vec(input logic [15:0] d, input logic [15:0] s, input logic [5:0] op,
                                  input logic [15:0] pin, input logic upd,
                                  input logic [15:0] eo, input logic [15:0] ep);
    vec_t v;
    v.d = d; v.s = s; v.op = op; v.pin = pin; v.upd = upd; v.eo = eo; v.ep = ep;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] d, input logic [15:0] s, input logic [5:0] op,
                       input logic [15:0] pin, input logic upd);
    bus.d_bus = d; bus.s_bus = s; bus.alu_op = op; bus.psw_in = pin; bus.psw_update = upd;
  endtask

  function automatic int sx(input int x, input int w);
    return (x >= (1 << (w - 1))) ? x - (1 << w) : x;
  endfunction

  function automatic int bcd2int(input int x, input int nd);
    int v = 0;
    for (int i = nd - 1; i >= 0; i--) v = v * 10 + ((x >> (4 * i)) & 15);
    return v;
  endfunction

  function automatic int int2bcd(input int v, input int nd);
    int r = 0;
    int t = v;
    for (int i = 0; i < nd; i++) begin
      r = r | ((t % 10) << (4 * i));
      t = t / 10;
    end
    return r;
  endfunction

  // Reference: returns {psw, result} from integer arithmetic on the w-bit operands.
  function automatic logic [31:0] model(input logic [15:0] d, input logic [15:0] s, input logic [5:0] aop,
                                        input logic [15:0] pin, input logic upd);
    int op, w, mask, lim, a, b, bb, cin, sum, sv, r, nd, p10, dv;
    bit eb, c, v, z, n, ch_c, ch_zn, ch_v, keep, supported;
    logic [15:0] res, psw;
    op = int'(aop[4:0]);
    eb = aop[5] && op != 15 && op != 16;
    w = eb ? 8 : 16;
    mask = (1 << w) - 1;
    lim = 1 << (w - 1);
    a = int'(d) & mask;
    b = int'(s) & mask;
    c = pin[0]; v = pin[4];
    ch_c = 0; ch_zn = 0; ch_v = 0; keep = 0; supported = 1; r = a;
    case (op)
      0, 1, 2, 3, 5: begin
        cin = (op == 0) ? 0 : ((op == 2 || op == 5) ? 1 : int'(c));
        bb = (op == 0 || op == 1) ? b : (~b & mask);
        sum = a + bb + cin;
        r = sum & mask;
        c = sum > mask;
        sv = sx(a, w) + sx(bb, w) + cin;
        v = (sv >= lim) || (sv < -lim);
        ch_c = 1; ch_zn = 1; ch_v = 1; keep = (op == 5);
      end
      4: begin
`ifdef XM23_ALU_DADD_EN
        nd = w / 4;
        p10 = 1;
        for (int i = 0; i < nd; i++) p10 = p10 * 10;
        dv = bcd2int(a, nd) + bcd2int(b, nd) + int'(c);
        c = dv >= p10;
        r = int2bcd(dv % p10, nd);
        ch_c = 1; ch_zn = 1;
`else
        supported = 0;
`endif
      end
      6, 7, 8, 9, 10, 11: begin
        case (op)
          6: r = a ^ b;
          8, 11: r = a | b;
          10: r = a & ~b & mask;
          default: r = a & b;
        endcase
        v = 0; ch_zn = 1; ch_v = 1; keep = (op == 9);
      end
      12: r = b;
      13: begin r = (sx(a, w) >>> 1) & mask; c = (a & 1) != 0; ch_c = 1; ch_zn = 1; end
      14: begin r = (int'(c) << (w - 1)) | (a >> 1); c = (a & 1) != 0; ch_c = 1; ch_zn = 1; end
      15: begin r = ((a & 255) << 8) | (a >> 8); ch_zn = 1; end
      16: begin r = sx(a & 255, 8) & 65535; ch_zn = 1; end
      default: supported = 0;
    endcase
    if (!supported) return {pin, d};
    z = (r == 0);
    n = ((r >> (w - 1)) & 1) != 0;
    res = keep ? d : (eb ? {d[15:8], 8'(r)} : 16'(r));
    psw = pin;
    if (upd) begin
      if (ch_c) psw[0] = c;
      if (ch_zn) begin psw[1] = z; psw[2] = n; end
      if (ch_v) psw[4] = v;
    end
    return {psw, res};
  endfunction

  function automatic logic [15:0] bcd_rand();
    logic [15:0] x;
    for (int i = 0; i < 4; i++) x[4*i +: 4] = 4'($urandom_range(0, 9));
    return x;
  endfunction

  initial begin
    logic [31:0] exp;
    logic [15:0] rd, rs, rp;
    logic [5:0]  rop;
    logic        ru;

    add_vec(16'h12AA, 16'h00AA, 6'h22, 16'h0000, 1'b1, 16'h1200, 16'h0003);
`ifdef XM23_ALU_DADD_EN
    add_vec(16'h0199, 16'h0001, 6'h04, 16'h0000, 1'b1, 16'h0200, 16'h0000);
    add_vec(16'h9999, 16'h0001, 6'h04, 16'h0000, 1'b1, 16'h0000, 16'h0003);
`else
    add_vec(16'h0199, 16'h0001, 6'h04, 16'h0000, 1'b1, 16'h0199, 16'h0000);
    add_vec(16'h9999, 16'h0001, 6'h04, 16'h0010, 1'b1, 16'h9999, 16'h0010);
`endif
    add_vec(16'h0001, 16'h0000, 6'h0E, 16'h0001, 1'b1, 16'h8000, 16'h0005);
    add_vec(16'h0001, 16'h0000, 6'h0E, 16'h0001, 1'b0, 16'h8000, 16'h0001);
    add_vec(16'h12F0, 16'h0000, 6'h0F, 16'h0000, 1'b1, 16'hF012, 16'h0004);
    add_vec(16'h12F0, 16'h0000, 6'h2F, 16'h0000, 1'b1, 16'hF012, 16'h0004);
    add_vec(16'h0080, 16'h0000, 6'h10, 16'h0000, 1'b1, 16'hFF80, 16'h0004);
    add_vec(16'hABCD, 16'h1234, 6'h2C, 16'h0013, 1'b1, 16'hAB34, 16'h0013);
    add_vec(16'h5555, 16'h1111, 6'h14, 16'hFFFF, 1'b1, 16'h5555, 16'hFFFF);
    add_vec(16'h0005, 16'h0005, 6'h05, 16'h0000, 1'b1, 16'h0005, 16'h0003);
    add_vec(16'h00F0, 16'h000F, 6'h09, 16'h0010, 1'b1, 16'h00F0, 16'h0002);
    add_vec(16'h34FF, 16'h0000, 6'h21, 16'h0001, 1'b1, 16'h3400, 16'h0003);
    add_vec(16'h8000, 16'h0001, 6'h02, 16'h0000, 1'b1, 16'h7FFF, 16'h0011);
    add_vec(16'h0081, 16'h0000, 6'h2D, 16'h0000, 1'b1, 16'h00C0, 16'h0005);

    rst = 1'b1;
    drive(16'h7FFF, 16'h0001, 6'h00, 16'h60E0, 1'b1);
    repeat (2) @(negedge clk);
    check("reset_out", bus.alu_out, 16'h0000);
    check("reset_psw", bus.alu_psw_out, 16'h0000);

    rst = 1'b0;
    @(negedge clk);
    check("first_add_out", bus.alu_out, 16'h8000);
    check("first_add_psw", bus.alu_psw_out, 16'h60F4);

    foreach (tbl[i]) begin
      drive(tbl[i].d, tbl[i].s, tbl[i].op, tbl[i].pin, tbl[i].upd);
      @(negedge clk);
      check($sformatf("vec%0d_out", i), bus.alu_out, tbl[i].eo);
      check($sformatf("vec%0d_psw", i), bus.alu_psw_out, tbl[i].ep);
    end

    drive(16'h0010, 16'h0020, 6'h00, 16'h0000, 1'b1);
    @(negedge clk);
    check("stream_a_out", bus.alu_out, 16'h0030);
    drive(16'h0100, 16'h0200, 6'h00, 16'h0000, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_out", bus.alu_out, 16'h0000);
    check("midreset_psw", bus.alu_psw_out, 16'h0000);
    rst = 1'b0;
    drive(16'hFFFF, 16'h0001, 6'h00, 16'h0100, 1'b1);
    @(negedge clk);
    check("after_reset_out", bus.alu_out, 16'h0000);
    check("after_reset_psw", bus.alu_psw_out, 16'h0103);

    for (int i = 0; i < 1500; i++) begin
      rop = 6'($urandom);
      rd  = 16'($urandom);
      rs  = 16'($urandom);
      rp  = 16'($urandom);
      ru  = 1'($urandom);
      if (rop[4:0] == 5'd4) begin
        rd = bcd_rand();
        rs = bcd_rand();
      end
      exp = model(rd, rs, rop, rp, ru);
      drive(rd, rs, rop, rp, ru);
      @(negedge clk);
      check($sformatf("rand%0d_op%0h_out", i, rop), bus.alu_out, exp[15:0]);
      check($sformatf("rand%0d_op%0h_psw", i, rop), bus.alu_psw_out, exp[31:16]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
